// File: rtl/si_tag_pkg.sv
// Shared tag-stream definitions.
// Contents: default tagtime/channel widths, the tag payload struct, the
// scheduler state encoding and the wrap-safe time ordering helper.
package si_tag_pkg;

    localparam int unsigned TAGTIME_WIDTH = 64;
    localparam int unsigned CHANNEL_WIDTH = 6;

    // One tag: absolute time plus signed channel (+n rising, -n falling).
    typedef struct packed {
        logic [TAGTIME_WIDTH-1:0] tagtime;
        logic [CHANNEL_WIDTH-1:0] channel;
    } tag_t;

    // EMPTY: no lanes pending. ISSUE: at least one lane still to be sent.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ISSUE = 1'b1
    } sched_state_t;

    // True when a is strictly later than b, robust to tagtime wrap.
    function automatic logic time_after(input logic [TAGTIME_WIDTH-1:0] a,
                                        input logic [TAGTIME_WIDTH-1:0] b);
        logic [TAGTIME_WIDTH-1:0] diff;
        diff = a - b;
        return !diff[TAGTIME_WIDTH-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/si_lane_priority_encoder.sv
// Lowest-set-bit priority encoder for the pending lane mask.
// Ports:
//   mask        in   pending lane mask
//   any         out  mask has at least one bit set
//   index       out  index of the lowest set bit (0 when mask is empty)
//   cleared     out  mask with its lowest set bit cleared
//   single_bit  out  mask has exactly one bit set
module si_lane_priority_encoder #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]       mask,
    output logic                   any,
    output logic [INDEX_WIDTH-1:0] index,
    output logic [WIDTH-1:0]       cleared,
    output logic                   single_bit
);

    always_comb begin
        any        = |mask;
        // Subtracting one borrows through the trailing zeros into the lowest set bit.
        cleared    = mask & (mask - WIDTH'(1));
        single_bit = any && (cleared == '0);
        index      = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/si_tag_lane_scheduler.sv
// Serializes a multi-lane, time-sorted tag beat into one tag per cycle,
// issuing lanes in ascending index order and tracking a monotonic lower
// bound on all future output tags.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   s_tvalid/s_tready    wide beat handshake (s_tready independent of s_tvalid)
//   s_tkeep              per-lane tag valid
//   s_tagtime/s_channel  per-lane tag payload
//   s_lowest_time_bound  upstream lower bound on future tags
//   m_tvalid/m_tready    single-tag handshake
//   m_tagtime/m_channel  issued tag payload
//   m_lane               source lane of the issued tag
//   m_lowest_time_bound  lower bound on all future m_ tags
//   tag_count            tags issued since reset, wrapping
module si_tag_lane_scheduler #(
    parameter int unsigned WORD_WIDTH    = 4,
    parameter int unsigned TAGTIME_WIDTH = 64,
    parameter int unsigned CHANNEL_WIDTH = 6,
    parameter int unsigned COUNT_WIDTH   = 32,
    localparam int unsigned LANE_WIDTH   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      s_tvalid,
    output logic                                      s_tready,
    input  logic [WORD_WIDTH-1:0]                     s_tkeep,
    input  logic [WORD_WIDTH-1:0][TAGTIME_WIDTH-1:0]  s_tagtime,
    input  logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0]  s_channel,
    input  logic [TAGTIME_WIDTH-1:0]                  s_lowest_time_bound,
    output logic                                      m_tvalid,
    input  logic                                      m_tready,
    output logic [TAGTIME_WIDTH-1:0]                  m_tagtime,
    output logic [CHANNEL_WIDTH-1:0]                  m_channel,
    output logic [LANE_WIDTH-1:0]                     m_lane,
    output logic [TAGTIME_WIDTH-1:0]                  m_lowest_time_bound,
    output logic [COUNT_WIDTH-1:0]                    tag_count
);

    import si_tag_pkg::*;

    sched_state_t state, state_next;

    logic [WORD_WIDTH-1:0][TAGTIME_WIDTH-1:0] hold_time;
    logic [WORD_WIDTH-1:0][CHANNEL_WIDTH-1:0] hold_chan;
    logic [WORD_WIDTH-1:0]                    pend, pend_next, pend_cleared;
    logic                                     pend_any, pend_single;
    logic [LANE_WIDTH-1:0]                    lane;

    logic [TAGTIME_WIDTH-1:0] bound, bound_next;
    logic [TAGTIME_WIDTH-1:0] diff_s, diff_m;
    logic                     s_newer, s_beats_tag;
    logic [COUNT_WIDTH-1:0]   count, count_next;
    logic                     issue, accept;

    // Lowest pending lane selects the output and the post-issue mask.
    si_lane_priority_encoder #(
        .WIDTH (WORD_WIDTH)
    ) u_prio (
        .mask       (pend),
        .any        (pend_any),
        .index      (lane),
        .cleared    (pend_cleared),
        .single_bit (pend_single)
    );

    // Output side is driven from holding registers only.
    assign m_tvalid            = (state == ST_ISSUE);
    assign m_lane              = lane;
    assign m_tagtime           = hold_time[lane];
    assign m_channel           = hold_chan[lane];
    assign m_lowest_time_bound = bound;
    assign tag_count           = count;

    assign issue    = m_tvalid && m_tready;
    // Ready when empty, or when the last pending lane leaves this cycle.
    assign s_tready = !pend_any || (pend_single && m_tready);
    assign accept   = s_tvalid && s_tready;

    // Signed distances from the current bound make the ordering wrap-safe.
    assign diff_s      = s_lowest_time_bound - bound;
    assign diff_m      = m_tagtime - bound;
    assign s_newer     = !diff_s[TAGTIME_WIDTH-1] && (diff_s != '0);
    assign s_beats_tag = $signed(diff_s) > $signed(diff_m);

    // Next-state, pending mask, bound and counter.
    always_comb begin
        pend_next  = pend;
        bound_next = bound;
        count_next = count;
        state_next = state;

        if (issue) begin
            pend_next  = pend_cleared;
            count_next = count + COUNT_WIDTH'(1);
        end
        if (accept) begin
            pend_next = s_tkeep;
        end

        if (accept && s_newer) begin
            bound_next = s_lowest_time_bound;
        end
        if (issue) begin
            bound_next = m_tagtime;
        end
        // Coincident issue and accept: keep whichever candidate is further ahead.
        if (issue && accept && s_newer && s_beats_tag) begin
            bound_next = s_lowest_time_bound;
        end

        state_next = (pend_next != '0) ? ST_ISSUE : ST_EMPTY;
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
            pend  <= '0;
            bound <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            bound <= bound_next;
            count <= count_next;
        end
    end

    // Beat holding registers; contents are irrelevant while nothing is pending.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_time <= s_tagtime;
            hold_chan <= s_channel;
        end
    end

endmodule

// File: tb/tb_si_tag_lane_scheduler.sv
// Self-checking bench for si_tag_lane_scheduler: scoreboard of expected tags
// fed from accepted beats, a table of beats, and hand-written corner sequences.
module tb_si_tag_lane_scheduler;

    localparam int unsigned WW = 4;
    localparam int unsigned TW = 64;
    localparam int unsigned CW = 6;
    localparam int unsigned NW = 32;
    localparam int unsigned LW = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    s_tvalid;
    logic                    s_tready;
    logic [WW-1:0]           s_tkeep;
    logic [WW-1:0][TW-1:0]   s_tagtime;
    logic [WW-1:0][CW-1:0]   s_channel;
    logic [TW-1:0]           s_lowest_time_bound;
    logic                    m_tvalid;
    logic                    m_tready;
    logic [TW-1:0]           m_tagtime;
    logic [CW-1:0]           m_channel;
    logic [LW-1:0]           m_lane;
    logic [TW-1:0]           m_lowest_time_bound;
    logic [NW-1:0]           tag_count;

    si_tag_lane_scheduler #(
        .WORD_WIDTH    (WW),
        .TAGTIME_WIDTH (TW),
        .CHANNEL_WIDTH (CW),
        .COUNT_WIDTH   (NW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_tvalid            (s_tvalid),
        .s_tready            (s_tready),
        .s_tkeep             (s_tkeep),
        .s_tagtime           (s_tagtime),
        .s_channel           (s_channel),
        .s_lowest_time_bound (s_lowest_time_bound),
        .m_tvalid            (m_tvalid),
        .m_tready            (m_tready),
        .m_tagtime           (m_tagtime),
        .m_channel           (m_channel),
        .m_lane              (m_lane),
        .m_lowest_time_bound (m_lowest_time_bound),
        .tag_count           (tag_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tagtime;
        logic [CW-1:0] channel;
        logic [LW-1:0] lane;
    } exp_tag_t;

    typedef struct {
        logic [WW-1:0]         keep;
        logic [WW-1:0][TW-1:0] t;
        logic [WW-1:0][CW-1:0] c;
        logic [TW-1:0]         lb;
        logic [TW-1:0]         exp_bound;
    } vec_t;

    exp_tag_t      sb[$];
    vec_t          tbl[5];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [NW-1:0] exp_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Scoreboard monitor: pushes accepted lanes, pops on each issue handshake,
    // and checks that a stalled tag stays put until it is taken.
    initial begin : monitor
        exp_tag_t      e;
        logic          have_hold;
        logic [TW-1:0] hold_t;
        logic [CW-1:0] hold_c;
        logic [LW-1:0] hold_l;
        have_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_hold = 1'b0;
            end else begin
                if (s_tvalid && s_tready) begin
                    for (int i = 0; i < int'(WW); i++) begin
                        if (s_tkeep[i]) begin
                            sb.push_back('{tagtime: s_tagtime[i], channel: s_channel[i], lane: LW'(i)});
                        end
                    end
                end
                if (have_hold) begin
                    check("hold_valid", 64'(m_tvalid), 64'd1);
                    check("hold_tagtime", m_tagtime, hold_t);
                    check("hold_channel", 64'(m_channel), 64'(hold_c));
                    check("hold_lane", 64'(m_lane), 64'(hold_l));
                end
                have_hold = 1'b0;
                if (m_tvalid) begin
                    if (m_tready) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL sb_pop: got tag %0d on lane %0d, expected no tag", m_tagtime, m_lane);
                        end else begin
                            e = sb.pop_front();
                            check("tag_tagtime", m_tagtime, e.tagtime);
                            check("tag_channel", 64'(m_channel), 64'(e.channel));
                            check("tag_lane", 64'(m_lane), 64'(e.lane));
                        end
                    end else begin
                        have_hold = 1'b1;
                        hold_t    = m_tagtime;
                        hold_c    = m_channel;
                        hold_l    = m_lane;
                    end
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [WW-1:0] keep, input logic [WW-1:0][TW-1:0] t,
                             input logic [WW-1:0][CW-1:0] c, input logic [TW-1:0] lb);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        s_tvalid            = 1'b1;
        s_tkeep             = keep;
        s_tagtime           = t;
        s_channel           = c;
        s_lowest_time_bound = lb;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", 64'(ok), 64'd1);
        if (ok) exp_count += NW'($countones(keep));
        @(posedge clk); #1;
        s_tvalid = 1'b0;
    endtask

    // Run with m_tready high until the scoreboard and the DUT are both empty.
    task automatic drain(input string name);
        bit done;
        done     = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!m_tvalid && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [WW-1:0][TW-1:0] tv;
        logic [WW-1:0][CW-1:0] cv;

        tbl[0] = '{4'b0001, {64'd0, 64'd0, 64'd0, 64'd6000}, {6'd0, 6'd0, 6'd0, 6'd7}, 64'd0, 64'd6000};
        tbl[1] = '{4'b1000, {64'd6100, 64'd0, 64'd0, 64'd0}, {6'(-5), 6'd0, 6'd0, 6'd0}, 64'd6050, 64'd6100};
        tbl[2] = '{4'b0110, {64'd0, 64'd6300, 64'd6200, 64'd0}, {6'd0, 6'(-1), 6'd2, 6'd0}, 64'd6150, 64'd6300};
        tbl[3] = '{4'b0000, {64'd0, 64'd0, 64'd0, 64'd0}, {6'd0, 6'd0, 6'd0, 6'd0}, 64'd6400, 64'd6400};
        tbl[4] = '{4'b0101, {64'd0, 64'd6600, 64'd0, 64'd6500}, {6'd0, 6'd9, 6'd0, 6'(-9)}, 64'd6400, 64'd6600};

        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tkeep = '0;
        s_tagtime = '0;
        s_channel = '0;
        s_lowest_time_bound = '0;
        m_tready = 1'b0;
        exp_count = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_tvalid", 64'(m_tvalid), 64'd0);
        check("reset_tready", 64'(s_tready), 64'd1);
        check("reset_count", 64'(tag_count), 64'd0);
        check("reset_bound", m_lowest_time_bound, 64'd0);

        // Reset in the middle of a stalled 4'b1010 beat.
        tv = {64'd40, 64'd0, 64'd20, 64'd0};
        cv = {6'd4, 6'd0, 6'd2, 6'd0};
        m_tready = 1'b0;
        send_beat(4'b1010, tv, cv, 64'd0);
        check("pre_rst_tvalid", 64'(m_tvalid), 64'd1);
        check("pre_rst_lane", 64'(m_lane), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_async_tvalid", 64'(m_tvalid), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        exp_count = '0;
        m_tready = 1'b1;
        @(negedge clk);
        check("post_rst_tready", 64'(s_tready), 64'd1);
        check("post_rst_count", 64'(tag_count), 64'd0);
        @(negedge clk);
        check("post_rst_no_tag", 64'(m_tvalid), 64'd0);

        // Single 3-tag beat with latency and s_tready profile.
        tv = {64'd400, 64'd0, 64'd200, 64'd100};
        cv = {6'd3, 6'd0, 6'(-2), 6'd1};
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tkeep = 4'b1011; s_tagtime = tv; s_channel = cv; s_lowest_time_bound = 64'd0;
        @(negedge clk);
        check("single_accept", 64'(s_tready), 64'd1);
        exp_count += NW'(3);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        check("single_latency_tvalid", 64'(m_tvalid), 64'd1);
        check("single_latency_tagtime", m_tagtime, 64'd100);
        check("single_tready_low1", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        check("single_tready_low2", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        check("single_tready_high", 64'(s_tready), 64'd1);
        @(posedge clk); #1;
        check("single_done", 64'(m_tvalid), 64'd0);
        check("single_count", 64'(tag_count), 64'(exp_count));
        check("single_bound", m_lowest_time_bound, 64'd400);

        // Back-to-back single-lane beats: full throughput, no bubbles.
        tv = '0;
        cv = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            tv[2] = TW'(1000 + i);
            cv[2] = CW'(i + 1);
            s_tvalid = 1'b1; s_tkeep = 4'b0100; s_tagtime = tv; s_channel = cv; s_lowest_time_bound = 64'd0;
            @(negedge clk);
            check("b2b_tready", 64'(s_tready), 64'd1);
            if (i > 0) check("b2b_no_bubble", 64'(m_tvalid), 64'd1);
            if (s_tready) exp_count += NW'(1);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        drain("b2b_drain");
        check("b2b_count", 64'(tag_count), 64'(exp_count));
        check("b2b_bound", m_lowest_time_bound, 64'd1005);

        // Four-tag beat under alternating m_tready.
        tv = {64'd2003, 64'd2002, 64'd2001, 64'd2000};
        cv = {6'd4, 6'd3, 6'd2, 6'd1};
        m_tready = 1'b0;
        send_beat(4'b1111, tv, cv, 64'd0);
        begin
            bit done;
            done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                m_tready = (i % 2 == 0);
                @(negedge clk);
                if (!m_tvalid && sb.size() == 0) begin
                    done = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            check("bp_drain", 64'(done), 64'd1);
        end
        check("bp_count", 64'(tag_count), 64'(exp_count));
        check("bp_bound", m_lowest_time_bound, 64'd2003);

        // Empty beats: bound update only, never backwards.
        m_tready = 1'b1;
        send_beat(4'b0000, '0, '0, 64'd5000);
        check("empty_tvalid", 64'(m_tvalid), 64'd0);
        check("empty_bound", m_lowest_time_bound, 64'd5000);
        send_beat(4'b0000, '0, '0, 64'd4000);
        check("empty_bound_monotonic", m_lowest_time_bound, 64'd5000);

        // Table of beats, each drained fully.
        for (int r = 0; r < 5; r++) begin
            send_beat(tbl[r].keep, tbl[r].t, tbl[r].c, tbl[r].lb);
            drain("tbl_drain");
            check("tbl_bound", m_lowest_time_bound, tbl[r].exp_bound);
            check("tbl_count", 64'(tag_count), 64'(exp_count));
        end

        // Coincident issue and accept: larger step from the bound wins.
        m_tready = 1'b1;
        tv = '0;
        cv = '0;
        @(posedge clk); #1;
        tv[0] = 64'd7000; cv[0] = 6'd1;
        s_tvalid = 1'b1; s_tkeep = 4'b0001; s_tagtime = tv; s_channel = cv; s_lowest_time_bound = 64'd6600;
        @(negedge clk);
        check("coin_accept_a", 64'(s_tready), 64'd1);
        @(posedge clk); #1;
        tv[0] = 64'd7600; cv[0] = 6'd2;
        s_tkeep = 4'b0001; s_tagtime = tv; s_channel = cv; s_lowest_time_bound = 64'd7500;
        @(negedge clk);
        check("coin_accept_b", 64'(s_tready), 64'd1);
        check("coin_issue_a", 64'(m_tvalid), 64'd1);
        @(posedge clk); #1;
        check("coin_lb_wins", m_lowest_time_bound, 64'd7500);
        s_tkeep = 4'b0000; s_lowest_time_bound = 64'd7550;
        @(negedge clk);
        check("coin_accept_c", 64'(s_tready), 64'd1);
        exp_count += NW'(2);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        check("coin_tag_wins", m_lowest_time_bound, 64'd7600);
        drain("coin_drain");
        check("coin_count", 64'(tag_count), 64'(exp_count));

        // Walk the bound up to near 2^64, then issue a wrapped tag.
        send_beat(4'b0000, '0, '0, 64'h4000_0000_0000_0000);
        send_beat(4'b0000, '0, '0, 64'h8000_0000_0000_0000);
        send_beat(4'b0000, '0, '0, 64'hC000_0000_0000_0000);
        send_beat(4'b0000, '0, '0, 64'hFFFF_FFFF_FFFF_FFF6);
        check("wrap_bound_high", m_lowest_time_bound, 64'hFFFF_FFFF_FFFF_FFF6);
        tv = '0;
        cv = '0;
        tv[0] = 64'd20;
        cv[0] = 6'd5;
        send_beat(4'b0001, tv, cv, 64'hFFFF_FFFF_FFFF_FFF6);
        @(posedge clk); #1;
        check("wrap_bound", m_lowest_time_bound, 64'd20);
        drain("wrap_drain");
        check("final_count", 64'(tag_count), 64'(exp_count));
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/si_tag_lane_scheduler.md
Name: si_tag_lane_scheduler

Overview:
Serializes the multi-lane tag bus produced by the tag converter (up to WORD_WIDTH tags per beat) into a single-tag-per-cycle stream for narrow downstream consumers such as histogrammers and coincidence units.
Issues valid lanes in ascending lane order, which preserves time ordering because the converter output is time-sorted.
Back-pressures the wide bus while a beat is being drained and maintains a monotonic lowest_time_bound for the narrow stream.

Parameters:
WORD_WIDTH, 4, number of tag lanes per input beat (DATA_WIDTH_IN/32 of the upstream converter)
TAGTIME_WIDTH, 64, tagtime width in subtime units
CHANNEL_WIDTH, 6, signed channel field width (+n rising, -n falling)
COUNT_WIDTH, 32, width of the issued-tag statistics counter

Ports:
clk  in  1  block clock
rst  in  1  asynchronous active-high reset
s_tvalid  in  1  wide beat valid
s_tready  out  1  wide beat accepted when s_tvalid && s_tready
s_tkeep  in  WORD_WIDTH  per-lane tag valid
s_tagtime  in  WORD_WIDTH x TAGTIME_WIDTH  per-lane tagtime
s_channel  in  WORD_WIDTH x CHANNEL_WIDTH  per-lane signed channel
s_lowest_time_bound  in  TAGTIME_WIDTH  upstream lower bound on future tags
m_tvalid  out  1  single-tag valid
m_tready  in  1  downstream ready
m_tagtime  out  TAGTIME_WIDTH  issued tagtime
m_channel  out  CHANNEL_WIDTH  issued channel
m_lane  out  clog2(WORD_WIDTH)  source lane of issued tag, for debug
m_lowest_time_bound  out  TAGTIME_WIDTH  lower bound on all future m_ tags
tag_count  out  COUNT_WIDTH  tags issued since reset; wraps modulo 2^COUNT_WIDTH

Behaviour:
- State: holding registers for one beat (tagtime, channel per lane), plus pending mask P[WORD_WIDTH]. The block is EMPTY when P==0 and ISSUE otherwise.
- Reset (async, immediate): P=0, m_tvalid=0, m_lowest_time_bound=0, tag_count=0. Holding data is don't-care. Reset mid-drain discards the remaining lanes with no partial output after deassertion.
- m_tvalid = |P. The output comes from the lowest set bit of P and is a mux of holding registers only, with no combinational path from s_* to m_*.
- Issue handshake: when m_tvalid && m_tready, clear the lowest set bit of P and increment tag_count.
- s_tready = (P==0) || (P has exactly one bit set && m_tready). This gives full throughput for single-tag beats. s_tready must not depend on s_tvalid.
- Accept (s_tvalid && s_tready): load the holding registers and set P <= s_tkeep. Same-cycle issue of the last pending lane and load of the new beat are both legal.
- A beat with s_tkeep==0 is accepted in one cycle, issues nothing, and still updates the bound.
- Latency: beat accepted at cycle N, its first tag is visible on m_ at N+1. A beat of k tags occupies k cycles with m_tready held high.
- m_tvalid, once high, is held with stable data until the handshake, including under m_tready=0.
- Bound update per cycle, applied in priority order (later items override earlier ones):
  1. On accept, if $signed(s_lowest_time_bound - m_lowest_time_bound) > 0, load s_lowest_time_bound.
  2. On an issue handshake, load the issued m_tagtime.
  3. If a handshake and an accept coincide, take the candidate with the larger signed difference against the current value.
- m_lowest_time_bound never decreases under signed-difference comparison. This handles 64-bit wrap.
- Any lane order other than ascending index is forbidden.

Decomposition:
- Shared package si_tag_pkg:
  - TAGTIME_WIDTH and CHANNEL_WIDTH constants.
  - typedef tag_t {tagtime, channel}.
  - function time_after(a,b) = $signed(a-b) > 0, reused by the converter and future mergers.
- One sub-module, si_lane_priority_encoder (combinational). Input: mask. Outputs: any, index of lowest set bit, mask with that bit cleared, single_bit flag.

Test Plan:
- Reset sequence: assert rst mid-drain with P=4'b1010 -> m_tvalid=0 in the same cycle; after release, s_tready=1 and tag_count=0.
- Single beat: s_tkeep=4'b1011 with tagtimes 100/200/–/400 and channels 1/-2/–/3, m_tready=1 -> m_ tags (100,1,lane0), (200,-2,lane1), (400,3,lane3) on consecutive cycles starting 1 cycle after accept. s_tready is low for 2 cycles, then high. tag_count=3.
- Back-to-back single-lane beats (s_tkeep=4'b0100 each cycle, m_tready=1) -> one tag per cycle, s_tready continuously 1, no bubbles.
- Backpressure: m_tready toggles 1010… during a 4-tag beat -> each tag held stable until accepted, ascending order kept, no tag lost or duplicated. Scoreboard against the input.
- Empty beat: s_tkeep=0 with s_lowest_time_bound=5000 -> accepted in 1 cycle, m_tvalid stays 0, m_lowest_time_bound=5000 next cycle. A following bound of 4000 leaves it at 5000.
- Wrap: bound at 2^64-10, tag with tagtime 20 issued -> m_lowest_time_bound becomes 20 (signed-difference rule).
